debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_chan.sv | 68 ++++++
 rtl/debounce_bank.sv | 37 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Holds the default sample threshold and the per-channel counter width function.
package debounce_pkg;

  localparam int unsigned DEFAULT_THRESH = 1000;

  // Counter must be able to hold every value up to THRESH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, qualifying-sample counter, stable output.
// Edge pulse registers exist only when DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are tied low.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned THRESH  = DEFAULT_THRESH,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic tick,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CW   = cnt_width(THRESH);
  localparam logic [CW-1:0]    LAST = CW'(THRESH - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RST_VAL;
      s     <= RST_VAL;
    end else begin
      sync1 <= in;
      s     <= sync1;
    end
  end

  assign accept = (s != out) && tick && (cnt == LAST);

  // Agreement with the current level wipes progress even between ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= RST_VAL;
    end else if (s == out) begin
      cnt <= '0;
    end else if (accept) begin
      out <= s;
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounce channels with a combined change flag.
// Edge outputs are live only when DEBOUNCE_EDGE_EN is defined; otherwise they read constant 0.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned    N       = 8,
  parameter int unsigned    THRESH  = DEFAULT_THRESH,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         tick,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .THRESH  (THRESH),
      .RST_VAL (RST_VAL[i])
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .in   (in[i]),
      .tick (tick),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule
